switch_port_arbiter: RTL
========================

SWITCH_PORT_ARBITER -- requirements
Module: switch_port_arbiter

Interface
REQ-001 Parameter DW, default 4: data width of every data port, in bits.
REQ-002 Parameter PORT, default 0: 2-bit output-port index this arbiter serves.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1 bit: synchronous reset, active-high.
REQ-006 Ports validtx_0..validtx_3, input, 1 bit each: requester n holds a word.
REQ-007 Ports adr_i_0..adr_i_3, input, 2 bits each: destination port of requester n's word.
REQ-008 Ports dat_i_0..dat_i_3, input, DW bits each: requester n's word.
REQ-009 Ports acktx_0..acktx_3, output, 1 bit each: one-cycle pulse, word of requester n taken.
REQ-010 Port dat_o, output, DW bits: registered word presented to the output device.
REQ-011 Port validrx, output, 1 bit: dat_o holds an unconsumed word.
REQ-012 Port ackrx, input, 1 bit: output device consumes dat_o.
REQ-013 Port grant_o, output, 2 bits: index of the last granted requester.
REQ-014 Port xfer_cnt, output, 8 bits: count of words consumed at the output.

Function
REQ-015 req_n SHALL be validtx_n AND (adr_i_n == PORT) AND NOT acktx_n.
REQ-016 The FSM SHALL have two states: IDLE (validrx=0) and BUSY (validrx=1).
REQ-017 Round-robin search SHALL start at grant_o+1 mod 4 and wrap 3->0; the first n with req_n set wins.
REQ-018 Arbitration SHALL take place in IDLE, or in BUSY when ackrx=1 in the same cycle.
REQ-019 On a winning edge: dat_o<=dat_i_n, validrx<=1, grant_o<=n, acktx_n<=1 for exactly the next cycle; all other acktx SHALL be 0.
REQ-020 Latency SHALL be one cycle: a request seen in cycle k produces validrx, dat_o and acktx_n in cycle k+1.
REQ-021 In BUSY with ackrx=0: dat_o, validrx and grant_o SHALL hold, and no acktx SHALL assert.
REQ-022 In BUSY with ackrx=1 and a winner: the FSM SHALL stay in BUSY and load the new word, giving back-to-back throughput of one word per cycle.
REQ-023 In BUSY with ackrx=1 and no winner: next state IDLE, validrx<=0, dat_o holds its last value.
REQ-024 ackrx while validrx=0 SHALL be ignored, with no state or count change.
REQ-025 xfer_cnt SHALL increment on every cycle with validrx=1 and ackrx=1, and wrap 255->0.
REQ-026 A requester with acktx_n=1 in cycle k SHALL NOT be granted in cycle k (REQ-015), even if validtx_n stays high; it is eligible again from cycle k+1.
REQ-027 Requests addressed to other ports SHALL never be acknowledged by this block.
REQ-028 Changes on validtx/adr_i/dat_i in BUSY with ackrx=0 SHALL have no effect on outputs.

Reset
REQ-029 With rst_i=1 at an edge, outputs SHALL be: validrx=0, dat_o=0, acktx_0..3=0, grant_o=3 (so requester 0 has first priority), xfer_cnt=0; state IDLE.
REQ-030 Reset SHALL override all other events in the same cycle, including mid-BUSY; the held word is discarded and not acknowledged a second time.

Verification (PORT=2, DW=4)
REQ-031 Reset: rst_i=1 for 2 cycles with random inputs -> all outputs at REQ-029 values, grant_o=3.
REQ-032 Single request: validtx_1=1, adr_i_1=2, dat_i_1=4'hA, ackrx=0 -> next cycle validrx=1, dat_o=A, acktx_1 high for 1 cycle, grant_o=1; dat_o holds A for 5 cycles with no further acktx; ackrx=1 -> xfer_cnt=1, validrx=0 next cycle.
REQ-033 Round robin: all four requesters valid to port 2 with data 0,1,2,3, ackrx=1 constantly -> grants 0,1,2,3,0 on consecutive cycles, dat_o=0,1,2,3,0, one acktx per cycle.
REQ-034 Address filter: validtx_3=1, adr_i_3=1 for 10 cycles -> validrx stays 0 and acktx_3 stays 0.
REQ-035 Counter wrap and mask: 256 accepted words -> xfer_cnt=0; a requester holding validtx high through its acktx cycle is not regranted in that cycle.
REQ-036 Reset mid-BUSY: validrx=1, rst_i=1 for 1 cycle -> next cycle validrx=0, xfer_cnt=0, grant_o=3, no acktx.

Source files
------------

// File: rtl/switch_port_arbiter.sv
// Round-robin arbiter for one output port of a 4-port switch.
// It accepts one word per cycle from the requesters whose destination matches PORT.
module switch_port_arbiter #(
  parameter int DW   = 4,
  parameter int PORT = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          validtx_0,
  input  logic          validtx_1,
  input  logic          validtx_2,
  input  logic          validtx_3,
  input  logic [1:0]    adr_i_0,
  input  logic [1:0]    adr_i_1,
  input  logic [1:0]    adr_i_2,
  input  logic [1:0]    adr_i_3,
  input  logic [DW-1:0] dat_i_0,
  input  logic [DW-1:0] dat_i_1,
  input  logic [DW-1:0] dat_i_2,
  input  logic [DW-1:0] dat_i_3,
  output logic          acktx_0,
  output logic          acktx_1,
  output logic          acktx_2,
  output logic          acktx_3,
  output logic [DW-1:0] dat_o,
  output logic          validrx,
  input  logic          ackrx,
  output logic [1:0]    grant_o,
  output logic [7:0]    xfer_cnt
);

  localparam logic [1:0] PORT_IDX = PORT[1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [3:0]      validtx;
  logic [1:0]      adr [4];
  logic [DW-1:0]   dat [4];
  logic [3:0]      ack_q, ack_next, req;
  logic            arb_en, win_found, take;
  logic [1:0]      win_idx, cand;

  assign validtx = {validtx_3, validtx_2, validtx_1, validtx_0};
  assign adr[0] = adr_i_0;
  assign adr[1] = adr_i_1;
  assign adr[2] = adr_i_2;
  assign adr[3] = adr_i_3;
  assign dat[0] = dat_i_0;
  assign dat[1] = dat_i_1;
  assign dat[2] = dat_i_2;
  assign dat[3] = dat_i_3;

  assign acktx_0 = ack_q[0];
  assign acktx_1 = ack_q[1];
  assign acktx_2 = ack_q[2];
  assign acktx_3 = ack_q[3];
  assign validrx = (state == BUSY);

  // A requester being acknowledged this cycle is masked so its stale word is not taken twice.
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) begin
      req[i] = validtx[i] && (adr[i] == PORT_IDX) && !ack_q[i];
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_o;
    cand      = grant_o;
    for (int i = 1; i <= 4; i++) begin
      cand = grant_o + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign arb_en = (state == IDLE) || ackrx;
  assign take   = arb_en && win_found;

  always_comb begin
    state_next = state;
    ack_next   = '0;
    if (take) begin
      ack_next = 4'(1) << win_idx;
    end
    case (state)
      IDLE: if (take) state_next = BUSY;
      BUSY: if (ackrx && !win_found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_o    <= '0;
      grant_o  <= 2'd3;
      ack_q    <= '0;
      xfer_cnt <= '0;
    end else begin
      ack_q <= ack_next;
      if (take) begin
        dat_o   <= dat[win_idx];
        grant_o <= win_idx;
      end
      if (validrx && ackrx) xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

endmodule
